// File: rtl/scurve_usb_framer.sv
// S-curve USB framer: buffers upstream words and emits header/seq/payload/[checksum]/trailer frames.
// Optional feature macro: SCURVE_FRAME_CHECKSUM_EN inserts an XOR checksum word before the trailer.
module scurve_usb_framer #(
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        in_wr_en,
  input  logic [15:0] in_din,
  input  logic        flush,
  input  logic        usb_data_fifo_full,
  output logic        usb_data_fifo_wr_en,
  output logic [15:0] usb_data_fifo_wr_din,
  output logic        in_full,
  output logic        overflow,
  output logic        frame_done,
  output logic        busy
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [11:0] LEN   = 12'(FRAME_LEN);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_TRL  = 3'd5
  } state_t;

`ifdef SCURVE_FRAME_CHECKSUM_EN
  localparam state_t S_CLOSE = S_CSUM;
`else
  localparam state_t S_CLOSE = S_TRL;
`endif

  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_seq;
  logic [11:0] r_count;
  logic [15:0] r_csum;
  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_head;
  logic        w_valid;
  logic [15:0] w_din;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == {(AW+1){1'b0}});
  assign w_full  = (w_level == DEPTH);
  assign w_push  = in_wr_en & ~w_full & ~reset;
  assign w_pop   = (r_state == S_DATA) & usb_data_fifo_wr_en;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Buffer pointers and sticky drop flag; a full buffer drops even if a pop frees a slot this cycle.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (in_wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Buffer storage.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_din;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: the same-cycle push lets the header go out one cycle after the first word lands.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty || w_push)       w_state_nxt = S_HDR;  else w_state_nxt = S_IDLE;
      S_HDR:  if (usb_data_fifo_wr_en)      w_state_nxt = S_SEQ;  else w_state_nxt = S_HDR;
      S_SEQ:  if (usb_data_fifo_wr_en)      w_state_nxt = S_DATA; else w_state_nxt = S_SEQ;
      S_DATA: begin
        if (usb_data_fifo_wr_en) begin
          if (r_count + 12'd1 == LEN) w_state_nxt = S_CLOSE;
          else                        w_state_nxt = S_DATA;
        end else if (w_empty && flush && (r_count != 12'd0)) begin
          w_state_nxt = S_CLOSE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_CSUM: if (usb_data_fifo_wr_en)      w_state_nxt = S_TRL;  else w_state_nxt = S_CSUM;
      S_TRL:  if (usb_data_fifo_wr_en)      w_state_nxt = S_IDLE; else w_state_nxt = S_TRL;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Emitted word and its validity per state.
  always_comb begin
    w_valid = 1'b0;
    w_din   = 16'h0000;
    case (r_state)
      S_HDR:  begin w_valid = 1'b1;     w_din = 16'h5343;         end
      S_SEQ:  begin w_valid = 1'b1;     w_din = r_seq;            end
      S_DATA: begin w_valid = ~w_empty; w_din = w_head;           end
      S_CSUM: begin w_valid = 1'b1;     w_din = r_csum;           end
      S_TRL:  begin w_valid = 1'b1;     w_din = {4'hE, r_count};  end
      default: begin w_valid = 1'b0;    w_din = 16'h0000;         end
    endcase
  end

  assign usb_data_fifo_wr_en  = w_valid & ~usb_data_fifo_full & ~reset;
  assign usb_data_fifo_wr_din = reset ? 16'h0000 : w_din;
  assign frame_done           = (r_state == S_TRL) & usb_data_fifo_wr_en;
  assign busy                 = (r_state != S_IDLE) & ~reset;
  assign in_full              = w_full & ~reset;
  assign overflow             = r_overflow;

  // Frame bookkeeping: payload count, running XOR and sequence number.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_seq   <= 16'h0000;
      r_count <= 12'd0;
      r_csum  <= 16'h0000;
    end else if (usb_data_fifo_wr_en) begin
      case (r_state)
        S_DATA: begin
          r_count <= r_count + 12'd1;
          r_csum  <= r_csum ^ w_head;
        end
        S_TRL: begin
          r_seq   <= r_seq + 16'd1;
          r_count <= 12'd0;
          r_csum  <= 16'h0000;
        end
        default: begin end
      endcase
    end
  end
endmodule

// File: tb/tb_scurve_usb_framer.sv
// Self-checking bench for scurve_usb_framer: directed scenarios plus randomized frames vs. a frame model.
// Honors SCURVE_FRAME_CHECKSUM_EN in its model so it matches either build.
module tb_scurve_usb_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_wr_en_a, in_wr_en_b, flush, usb_full;
  logic [15:0] in_din;
  logic        wr_en_a, in_full_a, ovf_a, fd_a_s, busy_a;
  logic        wr_en_b, in_full_b, ovf_b, fd_b_s, busy_b;
  logic [15:0] din_a, din_b;

  int total = 0, bad = 0, cyc = 0, fd_a = 0, fd_b = 0;
  logic [15:0] act_a[$];
  logic [15:0] act_b[$];
  int          cyc_a[$];
  logic [15:0] seq_a = 16'h0000, seq_b = 16'h0000;
  bit          rand_stall = 1'b0;

  scurve_usb_framer #(.FRAME_LEN(4), .FIFO_DEPTH(16)) u_a (
    .Clk(clk), .reset(reset), .in_wr_en(in_wr_en_a), .in_din(in_din), .flush(flush),
    .usb_data_fifo_full(usb_full), .usb_data_fifo_wr_en(wr_en_a), .usb_data_fifo_wr_din(din_a),
    .in_full(in_full_a), .overflow(ovf_a), .frame_done(fd_a_s), .busy(busy_a));

  scurve_usb_framer #(.FRAME_LEN(64), .FIFO_DEPTH(16)) u_b (
    .Clk(clk), .reset(reset), .in_wr_en(in_wr_en_b), .in_din(in_din), .flush(flush),
    .usb_data_fifo_full(usb_full), .usb_data_fifo_wr_en(wr_en_b), .usb_data_fifo_wr_din(din_b),
    .in_full(in_full_b), .overflow(ovf_b), .frame_done(fd_b_s), .busy(busy_b));

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_a) begin act_a.push_back(din_a); cyc_a.push_back(cyc + 1); end
    if (wr_en_b) act_b.push_back(din_b);
    if (fd_a_s) fd_a <= fd_a + 1;
    if (fd_b_s) fd_b <= fd_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stall) usb_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push_a(input logic [15:0] w);
    in_din = w; in_wr_en_a = 1'b1; tick(); in_wr_en_a = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] w);
    in_din = w; in_wr_en_b = 1'b1; tick(); in_wr_en_b = 1'b0;
  endtask

  // Reference: split accepted words into chunks of flen, each closed as a full frame.
  task automatic model_frames(input logic [15:0] w[$], input int flen, input logic [15:0] seq0,
                              output logic [15:0] exp[$], output int nfr);
    logic [15:0] s;
    logic [15:0] x;
    int n;
    s = seq0; exp = {}; nfr = 0;
    for (int i = 0; i < w.size(); i += flen) begin
      n = (w.size() - i < flen) ? (w.size() - i) : flen;
      exp.push_back(16'h5343);
      exp.push_back(s);
      x = 16'h0000;
      for (int j = 0; j < n; j++) begin
        exp.push_back(w[i+j]);
        x = x ^ w[i+j];
      end
`ifdef SCURVE_FRAME_CHECKSUM_EN
      exp.push_back(x);
`endif
      exp.push_back({4'hE, 12'(n)});
      s = s + 16'd1;
      nfr++;
    end
  endtask

  task automatic wait_words(input bit sel_b, input int n, input int budget);
    int t = 0;
    while (((sel_b ? act_b.size() : act_a.size()) < n) && (t < budget)) begin
      tick();
      t++;
    end
    total++;
    if ((sel_b ? act_b.size() : act_a.size()) < n) begin
      bad++;
      $display("FAIL wait_words: got %0d words, want %0d", sel_b ? act_b.size() : act_a.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_wr_en_a = 1'b1; in_din = 16'hBEEF;
    repeat (3) tick();
    total += 6;
    if (wr_en_a !== 1'b0)     begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en_a); end
    if (fd_a_s !== 1'b0)      begin bad++; $display("FAIL rst_frame_done: got %b want 0", fd_a_s); end
    if (busy_a !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    if (in_full_a !== 1'b0)   begin bad++; $display("FAIL rst_in_full: got %b want 0", in_full_a); end
    if (din_a !== 16'h0000)   begin bad++; $display("FAIL rst_wr_din: got %h want 0000", din_a); end
    if (ovf_a !== 1'b0)       begin bad++; $display("FAIL rst_overflow: got %b want 0", ovf_a); end
    in_wr_en_a = 1'b0; reset = 1'b0;
    repeat (4) tick();
    total += 2;
    if (busy_a !== 1'b0)      begin bad++; $display("FAIL rst_ignore_busy: got %b want 0", busy_a); end
    if (act_a.size() !== 0)   begin bad++; $display("FAIL rst_ignore_out: got %0d words want 0", act_a.size()); end
  endtask

  task automatic test_full_frame();
    logic [15:0] w[$];
    logic [15:0] exp[$];
    int base, fdb, nfr, stamp0;
    base = act_a.size(); fdb = fd_a; stamp0 = cyc + 1;
    for (int i = 1; i <= 4; i++) begin w.push_back(16'(i)); push_a(16'(i)); end
    model_frames(w, 4, seq_a, exp, nfr); seq_a = seq_a + 16'(nfr);
    wait_words(1'b0, base + exp.size(), 50);
    repeat (4) tick();
    total++;
    if (act_a.size() !== base + exp.size()) begin bad++; $display("FAIL full_len: got %0d want %0d", act_a.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total += 2;
      if (act_a[base+i] !== exp[i]) begin bad++; $display("FAIL full_word[%0d]: got %h want %h", i, act_a[base+i], exp[i]); end
      if (cyc_a[base+i] !== stamp0 + 1 + i) begin bad++; $display("FAIL full_cycle[%0d]: got %0d want %0d", i, cyc_a[base+i], stamp0 + 1 + i); end
    end
    total++;
    if (fd_a - fdb !== 1) begin bad++; $display("FAIL full_frame_done: got %0d want 1", fd_a - fdb); end
  endtask

  task automatic test_short_flush();
    logic [15:0] w[$];
    logic [15:0] exp[$];
    int base, fdb, nfr;
    base = act_b.size(); fdb = fd_b;
    for (int i = 0; i < 3; i++) begin w.push_back(16'($urandom)); push_b(w[i]); end
    flush = 1'b1;
    model_frames(w, 64, seq_b, exp, nfr); seq_b = seq_b + 16'(nfr);
    wait_words(1'b1, base + exp.size(), 50);
    repeat (4) tick();
    flush = 1'b0;
    total++;
    if (act_b.size() !== base + exp.size()) begin bad++; $display("FAIL short_len: got %0d want %0d", act_b.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (act_b[base+i] !== exp[i]) begin bad++; $display("FAIL short_word[%0d]: got %h want %h", i, act_b[base+i], exp[i]); end
    end
    total++;
    if (fd_b - fdb !== 1) begin bad++; $display("FAIL short_frame_done: got %0d want 1", fd_b - fdb); end
  endtask

  task automatic test_flush_idle();
    int base;
    base = act_a.size();
    flush = 1'b1;
    repeat (10) tick();
    total += 2;
    if (busy_a !== 1'b0)       begin bad++; $display("FAIL flush_idle_busy: got %b want 0", busy_a); end
    if (act_a.size() !== base) begin bad++; $display("FAIL flush_idle_out: got %0d words want 0", act_a.size() - base); end
    flush = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] w[$];
    logic [15:0] exp[$];
    int base, fdb, nfr;
    base = act_a.size(); fdb = fd_a;
    w = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) push_a(w[i]);
    model_frames(w, 4, seq_a, exp, nfr); seq_a = seq_a + 16'(nfr);
    wait_words(1'b0, base + 3, 30);
    usb_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total += 2;
      if (wr_en_a !== 1'b0)    begin bad++; $display("FAIL stall_wr_en[%0d]: got %b want 0", i, wr_en_a); end
      if (din_a !== 16'h2222)  begin bad++; $display("FAIL stall_din[%0d]: got %h want 2222", i, din_a); end
    end
    tick();
    usb_full = 1'b0; flush = 1'b1;
    wait_words(1'b0, base + exp.size(), 50);
    repeat (4) tick();
    flush = 1'b0;
    total++;
    if (act_a.size() !== base + exp.size()) begin bad++; $display("FAIL stall_len: got %0d want %0d", act_a.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (act_a[base+i] !== exp[i]) begin bad++; $display("FAIL stall_word[%0d]: got %h want %h", i, act_a[base+i], exp[i]); end
    end
    total++;
    if (fd_a - fdb !== 1) begin bad++; $display("FAIL stall_frame_done: got %0d want 1", fd_a - fdb); end
  endtask

  task automatic test_overflow();
    logic [15:0] w[$];
    logic [15:0] exp[$];
    int base, fdb, nfr;
    base = act_a.size(); fdb = fd_a;
    usb_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) w.push_back(16'h0100 + 16'(i));
      push_a(16'h0100 + 16'(i));
    end
    total += 2;
    if (in_full_a !== 1'b1) begin bad++; $display("FAIL ovf_in_full: got %b want 1", in_full_a); end
    if (ovf_a !== 1'b1)     begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf_a); end
    model_frames(w, 4, seq_a, exp, nfr); seq_a = seq_a + 16'(nfr);
    usb_full = 1'b0;
    wait_words(1'b0, base + exp.size(), 100);
    repeat (4) tick();
    total++;
    if (act_a.size() !== base + exp.size()) begin bad++; $display("FAIL ovf_len: got %0d want %0d", act_a.size() - base, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (act_a[base+i] !== exp[i]) begin bad++; $display("FAIL ovf_word[%0d]: got %h want %h", i, act_a[base+i], exp[i]); end
    end
    total += 2;
    if (fd_a - fdb !== nfr) begin bad++; $display("FAIL ovf_frame_done: got %0d want %0d", fd_a - fdb, nfr); end
    if (ovf_a !== 1'b1)     begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_a); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[$];
    logic [15:0] exp[$];
    int base, base2, nfr;
    base = act_a.size();
    for (int i = 0; i < 3; i++) push_a(16'hA001 + 16'(i));
    wait_words(1'b0, base + 4, 30);
    reset = 1'b1; tick(); reset = 1'b0;
    seq_a = 16'h0000;
    repeat (2) tick();
    total += 2;
    if (ovf_a !== 1'b0)            begin bad++; $display("FAIL mid_ovf_clear: got %b want 0", ovf_a); end
    if (act_a.size() !== base + 4) begin bad++; $display("FAIL mid_abandon: got %0d words want 4", act_a.size() - base); end
    base2 = act_a.size();
    w = '{16'h5A5A};
    push_a(16'h5A5A); flush = 1'b1;
    model_frames(w, 4, seq_a, exp, nfr); seq_a = seq_a + 16'(nfr);
    wait_words(1'b0, base2 + exp.size(), 50);
    repeat (4) tick();
    flush = 1'b0;
    total++;
    if (act_a.size() !== base2 + exp.size()) begin bad++; $display("FAIL mid_len: got %0d want %0d", act_a.size() - base2, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (act_a[base2+i] !== exp[i]) begin bad++; $display("FAIL mid_word[%0d]: got %h want %h", i, act_a[base2+i], exp[i]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [15:0] w[$];
      logic [15:0] exp[$];
      int base, fdb, nfr, n;
      base = act_a.size(); fdb = fd_a;
      n = $urandom_range(1, 15);
      rand_stall = 1'b1;
      for (int i = 0; i < n; i++) begin
        w.push_back(16'($urandom));
        push_a(w[i]);
        repeat ($urandom_range(0, 2)) tick();
      end
      flush = 1'b1;
      model_frames(w, 4, seq_a, exp, nfr); seq_a = seq_a + 16'(nfr);
      wait_words(1'b0, base + exp.size(), 2000);
      rand_stall = 1'b0; usb_full = 1'b0;
      repeat (4) tick();
      flush = 1'b0;
      total++;
      if (act_a.size() !== base + exp.size()) begin bad++; $display("FAIL rnd%0d_len: got %0d want %0d", r, act_a.size() - base, exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (act_a[base+i] !== exp[i]) begin bad++; $display("FAIL rnd%0d_word[%0d]: got %h want %h", r, i, act_a[base+i], exp[i]); end
      end
      total += 2;
      if (fd_a - fdb !== nfr) begin bad++; $display("FAIL rnd%0d_frame_done: got %0d want %0d", r, fd_a - fdb, nfr); end
      if (ovf_a !== 1'b0)     begin bad++; $display("FAIL rnd%0d_overflow: got %b want 0", r, ovf_a); end
    end
  endtask

  initial begin
    reset = 1'b1; in_wr_en_a = 1'b0; in_wr_en_b = 1'b0; flush = 1'b0; usb_full = 1'b0; in_din = 16'h0000;
    test_reset();
    test_full_frame();
    test_short_flush();
    test_flush_idle();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scurve_usb_framer.md
SCURVE_USB_FRAMER -- requirements
Module: scurve_usb_framer

Interface
REQ-001 Parameter FRAME_LEN, default 64, meaning: maximum payload words per frame (2..4095).
REQ-002 Parameter FIFO_DEPTH, default 16, meaning: internal input buffer depth (power of 2).
REQ-003 Clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_wr_en  input  1  upstream S-curve word strobe (from test-control USB write port).
REQ-006 in_din  input  16  upstream S-curve data word.
REQ-007 flush  input  1  level; close the current frame once the buffer drains (tied to S-curve test done).
REQ-008 usb_data_fifo_full  input  1  USB data FIFO full.
REQ-009 usb_data_fifo_wr_en  output  1  USB data FIFO write strobe.
REQ-010 usb_data_fifo_wr_din  output  16  USB data FIFO write word.
REQ-011 in_full  output  1  internal buffer full.
REQ-012 overflow  output  1  sticky: an input word was dropped.
REQ-013 frame_done  output  1  one-cycle pulse on trailer write.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Frame format, in order: header 0x5343; sequence word seq[15:0]; payload words; optional checksum (REQ-034); trailer {4'hE, count[11:0]}, where count = payload words in the frame.
REQ-016 The buffer is a FIFO_DEPTH x 16 FIFO; in_wr_en with in_full low stores in_din; in_wr_en with in_full high drops the word and sets overflow, including in cycles when the same-cycle read would free a slot.
REQ-017 FSM states: IDLE, HDR, SEQ, DATA, CSUM, TRL.
REQ-018 IDLE -> HDR when the buffer is non-empty.
REQ-019 In every emit state, usb_data_fifo_wr_en = state-valid AND NOT usb_data_fifo_full; wr_en and wr_din are combinational from state/buffer head.
REQ-020 The state advances only on a cycle in which wr_en is high; when usb_data_fifo_full is high, the state holds and wr_din is stable.
REQ-021 HDR writes 0x5343 -> SEQ; SEQ writes seq -> DATA.
REQ-022 DATA is valid only when the buffer is non-empty; each write pops one word, increments count, and updates the checksum.
REQ-023 DATA -> CSUM (macro defined) or TRL (macro undefined) after the write that makes count = FRAME_LEN.
REQ-024 DATA -> CSUM/TRL when flush is high, the buffer is empty, and count > 0; otherwise DATA waits on an empty buffer.
REQ-025 TRL writes the trailer, pulses frame_done, increments seq (wraps at 0xFFFF -> 0), clears count and checksum -> IDLE.
REQ-026 flush in IDLE with an empty buffer produces no output.
REQ-027 flush rising while frames are pending causes all buffered words to be framed before the final short frame closes.
REQ-028 Throughput: one output word per Clk when the USB FIFO is not full and data is available; first header write occurs 1 cycle after the first buffered word enters the FIFO.
REQ-029 overflow clears only on reset.

Reset
REQ-030 While reset is high on a clock edge, state goes to IDLE; the buffer empties; seq, count, checksum and overflow clear.
REQ-031 During reset, usb_data_fifo_wr_en = 0, frame_done = 0, busy = 0, in_full = 0, and usb_data_fifo_wr_din = 0x0000.
REQ-032 Reset mid-frame abandons the frame with no trailer; the next frame uses seq 0.
REQ-033 in_wr_en is ignored while reset is high.

Configuration
REQ-034 Macro SCURVE_FRAME_CHECKSUM_EN: when defined, state CSUM writes the XOR of all payload words of the frame (0x0000 for none) before TRL; when undefined, CSUM is never entered and DATA goes directly to TRL.

Verification
REQ-035 Bench, FRAME_LEN=4, macro defined, 4 words 0x0001..0x0004, full low -> 8 consecutive writes: 5343, 0000, 0001, 0002, 0003, 0004, 0004, E004; frame_done pulses once.
REQ-036 Bench, same stimulus with macro undefined -> 7 writes ending 0004, E004.
REQ-037 Bench, FRAME_LEN=64, 3 words then flush -> frame 5343, 0000, w0, w1, w2, [xor], E003.
REQ-038 Bench, usb_data_fifo_full high for 5 cycles during DATA -> no wr_en, wr_din held, no word lost or duplicated.
REQ-039 Bench, 17 words in consecutive cycles with full held high (FIFO_DEPTH=16) -> in_full high, 17th word dropped, overflow = 1.
REQ-040 Bench, reset pulsed mid-DATA, then 1 word plus flush -> new frame uses seq 0x0000, trailer E001.
